pio_debounced_port: RTL
=======================

Name: pio_debounced_port

Overview:
- Parametrised Avalon-MM parallel I/O port for board switches, pushbuttons and expansion headers. Generalises the fixed-width PIO exports of the Nios system.
- Per-bit direction control, 2-FF input synchronisation, per-bit debounce, programmable edge capture, atomic set/clear of outputs, and a maskable level interrupt.
- Sits inside the Nios system. The top level builds the tristate as gpio_oe ? gpio_out : 'z.

Parameters:
- WIDTH, 8, number of channels (1..32).
- DEBOUNCE_CYCLES, 50000, input must be stable this many clocks before it is accepted (1 ms at 50 MHz; minimum 2).
- EDGE_MODE, 0, edge that sets capture: 0 rising, 1 falling, 2 any.
- RESET_OUT, 0, WIDTH-bit reset value of the output data register.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- gpio_in  in  WIDTH  raw pin inputs (asynchronous).
- gpio_out  out  WIDTH  output data.
- gpio_oe  out  WIDTH  per-bit output enable (1 = drive).
- irq  out  1  level interrupt, registered.

Behaviour:
- Clock and reset: one clock, CLOCK_50. reset_n is asynchronous, active-low, and applies to all flops.
- Reset values:
  - readdata = 0, gpio_out = RESET_OUT, gpio_oe = 0, irq = 0.
  - direction = 0, mask = 0, capture = 0.
  - Sync flops = 0, stable = 0, debounce counters = 0.
- Register map (bits above WIDTH read as 0 and are ignored on write):
  - 0 DATA. Read returns per bit: oe ? out_reg : stable. Write loads out_reg.
  - 1 DIRECTION. R/W, 1 = output.
  - 2 IRQ_MASK. R/W.
  - 3 EDGE_CAPTURE. Read returns capture bits. Write-1-to-clear.
  - 4 OUTSET. Write-only: out_reg |= wd. Reads 0.
  - 5 OUTCLR. Write-only: out_reg &= ~wd. Reads 0.
  - 6, 7. Read 0, writes ignored.
- Bus timing:
  - Access requires chipselect.
  - Read latency is 1: readdata is valid the cycle after read, and holds until the next read.
  - Writes take effect on the clock edge they are sampled.
- Input path:
  - gpio_in passes through a 2-FF synchroniser per bit.
  - Each bit has a debounce counter, width clog2(DEBOUNCE_CYCLES).
  - If sync == stable, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES therefore never changes stable.
  - Latency from a pin change to stable is 2 + DEBOUNCE_CYCLES clocks.
- Edge capture:
  - stable_d is stable delayed one clock. The edge is detected from stable vs stable_d according to EDGE_MODE.
  - A detected edge sets the capture bit. Output-direction bits still capture.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Interrupt: irq <= |(capture & mask), registered. It deasserts 1 clock after the last masked bit is cleared.
- Output write collisions:
  - Only one register is written per cycle, so there is no collision between DATA, OUTSET and OUTCLR.
  - A direction change takes effect on gpio_oe the next cycle. out_reg is retained.
- Reset mid-debounce: reset aborts the debounce count. After release, inputs already high take 2 + DEBOUNCE_CYCLES clocks to reach stable, and produce a rising edge capture.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- Defined: debounce counters as described above.
- Undefined:
  - Counters are removed and stable <= sync each clock.
  - Pin-to-stable latency is 3 clocks.
  - DEBOUNCE_CYCLES is ignored.
- Register map and edge behaviour are identical in both builds.

Decomposition:
- Package pio_pkg:
  - Register address localparams ADDR_DATA..ADDR_OUTCLR.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY constants.
  - Bus data width 32.
- Sub-module pio_debounce_bit:
  - Contains the synchroniser, counter and stable flop for one bit, parametrised by DEBOUNCE_CYCLES.
  - Instantiated WIDTH times with generate.
  - The PIO_DEBOUNCE_EN switch lives inside it.

Test Plan:
1. Reset with RESET_OUT=8'hA5 -> gpio_out=A5, gpio_oe=00, irq=0. Reading DATA with gpio_in held 00 after 2+DEBOUNCE_CYCLES clocks -> 0.
2. Bounce: DEBOUNCE_CYCLES=16, bit0 toggles every 5 clocks for 40 clocks then holds 1 -> stable bit0 rises exactly 18 clocks after the last toggle; EDGE_CAPTURE=01; no capture during bouncing.
3. Set/clear: write DIRECTION=FF, DATA=0F, OUTSET=30, OUTCLR=03 -> gpio_out=0F, 3F, 3C on successive cycles; read DATA=3C.
4. Interrupt: IRQ_MASK=04, rising edge on bit2 -> irq=1. Write EDGE_CAPTURE=04 -> irq=0 one clock later. Edge on bit3 (unmasked) -> irq stays 0, capture=08.
5. Collision: debounced edge on bit1 in the same cycle as a write EDGE_CAPTURE=02 -> capture bit1 remains 1.
6. EDGE_MODE=2, bit5 goes 0->1->0 with debounce satisfied -> capture set after each edge. Assert reset_n low mid-count -> all state 0 immediately, asynchronously.

Source files
------------

// File: rtl/pio_pkg.sv
// pio_pkg: shared constants for the debounced parallel I/O port.
// Register word addresses, edge-mode codes and bus data width.
package pio_pkg;

  localparam int BUS_W = 32;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: 2-FF synchroniser plus debounce filter for one pin.
// Ports: clk, rst_n, pin (async in), stable (filtered, registered).
// Macro PIO_DEBOUNCE_EN: defined -> hold counter; undefined -> stable
// follows the synchroniser every clock (DEBOUNCE_CYCLES ignored).
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  if (DB_EN && DEBOUNCE_CYCLES > 1) begin : g_db
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST =
      CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Any return to the accepted level restarts the hold window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt    <= '0;
        stable <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end else begin : g_pass
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stable <= 1'b0;
      else        stable <= s2;
    end
  end

endmodule

// File: rtl/pio_debounced_port.sv
// pio_debounced_port: Avalon-MM PIO with per-bit direction, debounce,
// edge capture, atomic set/clear and a maskable level irq.
// Ports: CLOCK_50, reset_n, address/chipselect/read/write/writedata,
// readdata (1-cycle latency), gpio_in, gpio_out, gpio_oe, irq.
// Debounce filter enabled by macro PIO_DEBOUNCE_EN.
module pio_debounced_port
  import pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [BUS_W-1:0] writedata,
  output logic [BUS_W-1:0] readdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] wd;
  logic [BUS_W-1:0] rd_mux;

  logic wr;
  logic rd;
  logic we_data;
  logic we_dir;
  logic we_mask;
  logic we_edge;
  logic we_set;
  logic we_clr;
  logic unused_wd;

  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  assign wr = chipselect & write;
  assign rd = chipselect & read;

  assign we_data = wr && (address == ADDR_DATA);
  assign we_dir  = wr && (address == ADDR_DIR);
  assign we_mask = wr && (address == ADDR_MASK);
  assign we_edge = wr && (address == ADDR_EDGE);
  assign we_set  = wr && (address == ADDR_OUTSET);
  assign we_clr  = wr && (address == ADDR_OUTCLR);

  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (CLOCK_50),
      .rst_n (reset_n),
      .pin   (gpio_in[i]),
      .stable(stable[i])
    );
  end

  always_comb begin
    edge_hit = '0;
    case (EDGE_MODE)
      EDGE_RISING:  edge_hit = stable & ~stable_d;
      EDGE_FALLING: edge_hit = ~stable & stable_d;
      default:      edge_hit = stable ^ stable_d;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:
        rd_mux[WIDTH-1:0] = (dir_reg & out_reg)
                          | (~dir_reg & stable);
      ADDR_DIR:  rd_mux[WIDTH-1:0] = dir_reg;
      ADDR_MASK: rd_mux[WIDTH-1:0] = mask_reg;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = cap_reg;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= RESET_OUT;
      dir_reg  <= '0;
      mask_reg <= '0;
      cap_reg  <= '0;
      stable_d <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      unique case (1'b1)
        we_data: out_reg <= wd;
        we_set:  out_reg <= out_reg | wd;
        we_clr:  out_reg <= out_reg & ~wd;
        default: ;
      endcase
      if (we_dir)  dir_reg  <= wd;
      if (we_mask) mask_reg <= wd;
      // A new edge outranks a same-cycle W1C of that bit.
      cap_reg  <= (we_edge ? (cap_reg & ~wd) : cap_reg)
                | edge_hit;
      stable_d <= stable;
      irq      <= |(cap_reg & mask_reg);
      if (rd) readdata <= rd_mux;
    end
  end

endmodule
